// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel driver: default geometry, the
// framebuffer channel layout, and the column engine state encoding.
package hub75_pkg;

    // Default panel geometry.
    localparam int DEF_COLS       = 64;
    localparam int DEF_COL_W      = 6;
    localparam int DEF_ROW_W      = 5;
    localparam int DEF_COLOR_BITS = 8;

    // A framebuffer word holds six colour channels, B0 in the LSBs.
    localparam int NUM_CH = 6;
    localparam int CH_B0  = 0 * DEF_COLOR_BITS;
    localparam int CH_G0  = 1 * DEF_COLOR_BITS;
    localparam int CH_R0  = 2 * DEF_COLOR_BITS;
    localparam int CH_B1  = 3 * DEF_COLOR_BITS;
    localparam int CH_G1  = 4 * DEF_COLOR_BITS;
    localparam int CH_R1  = 5 * DEF_COLOR_BITS;

    // Column shift sequence: five cycles per column plus one tail cycle.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SETUP   = 3'd3,
        ST_CLK_HI1 = 3'd4,
        ST_CLK_HI2 = 3'd5,
        ST_TAIL    = 3'd6
    } state_t;

    // Bit offset of channel ch inside a framebuffer word of the given depth.
    function automatic int chan_offset(input int ch, input int color_bits);
        return ch * color_bits;
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and count enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    // Clear has priority over counting; wraps naturally at 2**WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (en) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/hub75_bitslice.sv
// Picks one bit position out of each of the six colour channels of a
// framebuffer word. Result is ordered {r1,g1,b1,r0,g0,b0}.
module hub75_bitslice
    import hub75_pkg::*;
#(
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int BIT_W      = $clog2(COLOR_BITS)
) (
    input  logic [NUM_CH*COLOR_BITS-1:0] fb_data,
    input  logic [BIT_W-1:0]             bit_idx,
    output logic [NUM_CH-1:0]            bits
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        logic [COLOR_BITS-1:0] chan;
        assign chan     = fb_data[chan_offset(gi, COLOR_BITS) +: COLOR_BITS];
        assign bits[gi] = chan[bit_idx];
    end

endmodule

// File: rtl/hub75_fetchshift.sv
// HUB75 column data engine: on start, reads one framebuffer word per column
// of the captured row pair, slices out the captured bit-plane and shifts it
// onto the six colour pins with a two-cycle-high pixel clock per column.
module hub75_fetchshift
    import hub75_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int COL_W      = DEF_COL_W,
    parameter int ROW_W      = DEF_ROW_W,
    parameter int COLOR_BITS = DEF_COLOR_BITS
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [2:0]                  bit_sel,
    input  logic [5:0]                  row_sel,
    output logic                        busy,
    output logic [ROW_W+COL_W-1:0]      fb_addr,
    output logic                        fb_rd,
    input  logic [NUM_CH*COLOR_BITS-1:0] fb_data,
    output logic                        r0,
    output logic                        g0,
    output logic                        b0,
    output logic                        r1,
    output logic                        g1,
    output logic                        b1,
    output logic                        pix_clk
);

    localparam int BIT_W = $clog2(COLOR_BITS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t                state_reg;
    logic [ROW_W-1:0]      row_q_reg;
    logic [BIT_W-1:0]      bit_q_reg;
    logic [NUM_CH-1:0]     pins_reg;
    logic                  busy_reg;
    logic                  fb_rd_reg;
    logic                  pix_clk_reg;
    logic [NUM_CH-1:0]     slice_bits;
    logic [COL_W-1:0]      col;
    logic                  col_en;
    logic                  col_clr;

    // Row bits above the panel height are deliberately ignored.
    if (ROW_W < 6) begin : g_row_hi
        logic unused_row_hi;
        assign unused_row_hi = ^row_sel[5:ROW_W];
    end

    // Column advances after the second high cycle except on the last column;
    // the tail cycle returns it to zero so the next row starts at column 0.
    assign col_en  = (state_reg == ST_CLK_HI2) && (col != LAST_COL);
    assign col_clr = rst || (state_reg == ST_TAIL);

    counter #(
        .WIDTH (COL_W)
    ) u_col_cnt (
        .clk (sys_clk),
        .rst (col_clr),
        .en  (col_en),
        .out (col)
    );

    hub75_bitslice #(
        .COLOR_BITS (COLOR_BITS),
        .BIT_W      (BIT_W)
    ) u_slice (
        .fb_data (fb_data),
        .bit_idx (bit_q_reg),
        .bits    (slice_bits)
    );

    // Sequencer: every output is registered and set on the edge entering the
    // state it belongs to. Pins load when leaving CAPTURE because the RAM word
    // is only valid during CAPTURE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            row_q_reg   <= '0;
            bit_q_reg   <= '0;
            pins_reg    <= '0;
            busy_reg    <= 1'b0;
            fb_rd_reg   <= 1'b0;
            pix_clk_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        row_q_reg <= row_sel[ROW_W-1:0];
                        bit_q_reg <= bit_sel[BIT_W-1:0];
                        busy_reg  <= 1'b1;
                        fb_rd_reg <= 1'b1;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    fb_rd_reg <= 1'b0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    pins_reg  <= slice_bits;
                    state_reg <= ST_SETUP;
                end
                ST_SETUP: begin
                    pix_clk_reg <= 1'b1;
                    state_reg   <= ST_CLK_HI1;
                end
                ST_CLK_HI1: begin
                    state_reg <= ST_CLK_HI2;
                end
                ST_CLK_HI2: begin
                    pix_clk_reg <= 1'b0;
                    if (col == LAST_COL) begin
                        state_reg <= ST_TAIL;
                    end else begin
                        fb_rd_reg <= 1'b1;
                        state_reg <= ST_READ;
                    end
                end
                ST_TAIL: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg    <= 1'b0;
                    fb_rd_reg   <= 1'b0;
                    pix_clk_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign fb_rd   = fb_rd_reg;
    assign fb_addr = {row_q_reg, col};
    assign pix_clk = pix_clk_reg;
    assign {r1, g1, b1, r0, g0, b0} = pins_reg;

endmodule
